pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the in-order MIPS core. It replaces the fixed 5-stage, load-use-only stall controller. It merges per-stage stall requests, owns the multi-cycle (mul/div) busy counter, issues flush and redirect for exceptions, and keeps stall statistics plus a deadlock watchdog. It sits beside the stage modules in `mycpu_core`, driving every stage's `stall` and `flush` inputs.

## Interface
- `STAGES`, default 5: number of pipeline stages; stage 1 = IF … stage STAGES = WB.
- `MC_STAGE`, default 3: stage index that hosts multi-cycle units (EX).
- `CNT_W`, default 6: width of the multi-cycle length field.
- `WDOG`, default 1024: consecutive stall[0] cycles before deadlock is flagged.

- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-low reset.
- `stallreq`  in  STAGES  bit s-1 = stage s requests stall (load-use from ID, SRAM wait, …).
- `mc_start`  in  1  one-cycle pulse: multi-cycle op entering MC_STAGE.
- `mc_len`  in  CNT_W  cycles the op occupies MC_STAGE; valid with mc_start; 0 treated as 1.
- `flush_req`  in  1  exception/eret commit from the WB-side exception logic.
- `flush_pc`  in  32  redirect target; valid with flush_req.
- `stall`  out  STAGES+1  bit 0 = PC register, bit s = stage s output register.
- `flush`  out  STAGES  bit s-1 clears stage s output register to a bubble.
- `new_pc_valid`  out  1  redirect strobe to IF.
- `new_pc`  out  32  redirect target.
- `mc_busy`  out  1  counter running.
- `mc_done`  out  1  last cycle of multi-cycle op.
- `stall_cycles`  out  32  count of cycles with stall[0]=1.
- `deadlock`  out  1  sticky watchdog flag.

## Operation
- Effective request r[s] = stallreq[s-1], OR (s==MC_STAGE and stall from the multi-cycle unit). The multi-cycle stall is active when mc_start=1 with effective length>1, or when mc_busy=1 and the counter is >1.
- Let k = highest s with r[s]=1. Then stall[0..k]=1 and stall[k+1..STAGES]=0. No request: all zero.
- Stage k+1 inserts a bubble by seeing stall[k]=1, stall[k+1]=0. That logic lives in the stage registers, not here.
- Multi-cycle counter:
  - IDLE→RUN on mc_start with length L>1; counter loads L-1.
  - RUN: the counter decrements each cycle. mc_done=1 when the counter is 1. Next state is IDLE.
  - When L≤1: mc_done=1 in the start cycle and no stall.
  - mc_start while RUN is ignored.
- Flush has the highest priority. When flush_req=1:
  - flush all ones, stall all zeros.
  - new_pc_valid=1 and new_pc=flush_pc in the same cycle.
  - The counter is forced to IDLE next cycle; mc_done is suppressed.
- stall_cycles increments when stall[0]=1 and wraps at 2^32.
- Watchdog counter:
  - Increments while stall[0]=1 and clears when stall[0]=0 or flush_req=1.
  - Reaching WDOG sets deadlock, which clears only on reset.

## Timing
- stall, flush, new_pc_valid, new_pc and mc_done are combinational from the inputs and registered state, with zero latency.
- mc_busy, counters and deadlock are registered.
- A multi-cycle op of length L holds stall[0..MC_STAGE] for exactly L-1 cycles starting in the mc_start cycle. The op leaves MC_STAGE on the L-th cycle.
- A stallreq in a stage above MC_STAGE during RUN extends the stall. The counter keeps decrementing, because the unit still computes.
- Reset (rst=0 at a clock edge) takes effect regardless of the current state, including mid-RUN:
  - mc_busy=0, counter=0, stall_cycles=0, watchdog=0, deadlock=0.
  - While rst=0, all combinational outputs are forced to 0.

## Structure
- A shared `defines.vh` holds:
  - `StallBus` redefined as STAGES+1.
  - Stage index constants (`STG_IF`…`STG_WB`).
  - The `MC_IDLE`/`MC_RUN` encodings.
- One sub-module, `mc_counter`: the IDLE/RUN state machine with its load/decrement counter and mc_busy/mc_done.
- The stall priority encoder, flush logic and statistics stay in `pipe_ctrl`.

## Test plan
- stallreq=5'b00010 (ID load-use), STAGES=5 → stall=6'b000111, flush=0; release → stall=0.
- mc_start with mc_len=33 → stall=6'b001111 for 32 cycles, mc_done on the 33rd cycle, mc_busy low afterwards. mc_len=1 → mc_done in the same cycle with no stall.
- flush_req with flush_pc=0xBFC00380 on cycle 10 of a 33-cycle op → flush=5'b11111, stall=0, new_pc=0xBFC00380, mc_busy=0 next cycle, no mc_done.
- stallreq[3] (MEM wait) and ID load-use together → stall=6'b011111.
- stallreq[0] held for 1024 cycles (WDOG=1024) → deadlock=1 and sticky, stall_cycles=1024. Reset → all zero.
- rst=0 asserted mid-RUN → outputs 0 the same cycle; after release the counter is IDLE and stall=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit and its
// multi-cycle counter.
package pipe_ctrl_pkg;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_RUN  = 1'b1
    } mc_state_e;

    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    // Stall bus carries the PC register plus one bit per stage output register.
    function automatic int unsigned stall_bus_w(input int unsigned stages);
        return stages + 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the core stage modules and pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned CNT_W  = 6
);
    import pipe_ctrl_pkg::*;

    logic [STAGES-1:0]                 stallreq;
    logic                              mc_start;
    logic [CNT_W-1:0]                  mc_len;
    logic                              flush_req;
    logic [31:0]                       flush_pc;
    logic [stall_bus_w(STAGES)-1:0]    stall;
    logic [STAGES-1:0]                 flush;
    logic                              new_pc_valid;
    logic [31:0]                       new_pc;
    logic                              mc_busy;
    logic                              mc_done;
    logic [31:0]                       stall_cycles;
    logic                              deadlock;

    modport master (
        output stallreq, mc_start, mc_len, flush_req, flush_pc,
        input  stall, flush, new_pc_valid, new_pc, mc_busy, mc_done,
               stall_cycles, deadlock
    );

    modport slave (
        input  stallreq, mc_start, mc_len, flush_req, flush_pc,
        output stall, flush, new_pc_valid, new_pc, mc_busy, mc_done,
               stall_cycles, deadlock
    );

endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle (mul/div) occupancy tracker: IDLE/RUN FSM with a
// load/decrement counter, producing the MC-stage stall, busy and done.
module mc_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_len,
    input  logic             flush_req,
    output logic             mc_stall,
    output logic             mc_busy,
    output logic             mc_done
);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff_len;
    logic             start_long;

    // A zero length behaves exactly like a single-cycle op.
    assign eff_len    = (mc_len == '0) ? CNT_W'(1) : mc_len;
    assign start_long = mc_start && (eff_len > CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_req) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    if (start_long) begin
                        state_d = MC_RUN;
                        cnt_d   = eff_len - CNT_W'(1);
                    end
                end
                MC_RUN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = MC_IDLE;
                    end
                end
                default: begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        mc_stall = 1'b0;
        mc_done  = 1'b0;
        if (rst && !flush_req) begin
            case (state_q)
                MC_IDLE: begin
                    mc_stall = start_long;
                    mc_done  = mc_start && !start_long;
                end
                MC_RUN: begin
                    mc_stall = cnt_q > CNT_W'(1);
                    mc_done  = cnt_q == CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mc_busy = (state_q == MC_RUN);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests into a prefix stall mask,
// drives flush/redirect, and keeps stall statistics plus a deadlock watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES   = 5,
    parameter int unsigned MC_STAGE = 3,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned WDOG     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int unsigned SB_W = stall_bus_w(STAGES);
    localparam int unsigned WD_W = $clog2(WDOG + 1);

    logic              mc_stall;
    logic [STAGES-1:0] req;
    logic [SB_W-1:0]   stall_o;
    logic              acc;
    logic              flush_act;

    logic [31:0]       sc_q, sc_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              dead_q, dead_d;

    mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
        .clk       (clk),
        .rst       (rst),
        .mc_start  (bus.mc_start),
        .mc_len    (bus.mc_len),
        .flush_req (bus.flush_req),
        .mc_stall  (mc_stall),
        .mc_busy   (bus.mc_busy),
        .mc_done   (bus.mc_done)
    );

    assign flush_act = rst && bus.flush_req;

    // Stall bit j is set when any stage at or above j requests: a running
    // OR from the WB end yields stall[0..k] for the highest requester k.
    always_comb begin
        req = bus.stallreq;
        if (mc_stall) begin
            req[MC_STAGE-1] = 1'b1;
        end
        acc     = 1'b0;
        stall_o = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            acc                 = acc | req[STAGES-1-i];
            stall_o[STAGES-i]   = acc;
        end
        stall_o[0] = acc;
        if (!rst || bus.flush_req) begin
            stall_o = '0;
        end
    end

    assign bus.stall        = stall_o;
    assign bus.flush        = flush_act ? '1 : '0;
    assign bus.new_pc_valid = flush_act;
    assign bus.new_pc       = flush_act ? bus.flush_pc : '0;

    always_comb begin
        sc_d = sc_q + 32'(stall_o[0]);
        wd_d = '0;
        if (stall_o[0] && !bus.flush_req) begin
            wd_d = (wd_q == WD_W'(WDOG)) ? wd_q : wd_q + WD_W'(1);
        end
        dead_d = dead_q || (wd_d == WD_W'(WDOG));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sc_q   <= '0;
            wd_q   <= '0;
            dead_q <= 1'b0;
        end else begin
            sc_q   <= sc_d;
            wd_q   <= wd_d;
            dead_q <= dead_d;
        end
    end

    assign bus.stall_cycles = sc_q;
    assign bus.deadlock     = dead_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios followed by random
// traffic, checked against a cycle-indexed behavioural model.
module tb_pipe_ctrl;

    localparam int STAGES   = 5;
    localparam int MC_STAGE = 3;
    localparam int CNT_W    = 6;
    localparam int WDOG     = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .STAGES   (STAGES),
        .MC_STAGE (MC_STAGE),
        .CNT_W    (CNT_W),
        .WDOG     (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  stall;
        logic [4:0]  flush;
        logic        npv;
        logic [31:0] npc;
        logic        busy;
        logic        done;
        logic [31:0] scyc;
        logic        dead;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: an op is remembered by its start cycle and length.
    bit          op_active = 0;
    int          op_start  = 0;
    int          op_len    = 0;
    int          cyc       = 0;
    logic [31:0] m_scyc    = '0;
    int          m_wd      = 0;
    bit          m_dead    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input logic [4:0] sreq, input bit st, input int ln,
                         input bit fr, input logic [31:0] fpc);
        exp_t e;
        int   i, reqs, k, l6;
        bit   mcstall, mcdone;
        @(posedge clk);
        #1;
        rst           = r;
        bus.stallreq  = sreq;
        bus.mc_start  = st;
        bus.mc_len    = CNT_W'(ln);
        bus.flush_req = fr;
        bus.flush_pc  = fpc;

        e.scyc  = m_scyc;
        e.dead  = m_dead;
        e.busy  = op_active;
        e.stall = '0;
        e.flush = '0;
        e.npv   = 1'b0;
        e.npc   = '0;
        e.done  = 1'b0;

        if (!r) begin
            op_active = 0;
            m_scyc    = '0;
            m_wd      = 0;
            m_dead    = 0;
        end else begin
            mcstall = 0;
            mcdone  = 0;
            if (!op_active && st) begin
                l6        = ln % 64;
                op_active = 1;
                op_start  = cyc;
                op_len    = (l6 == 0) ? 1 : l6;
            end
            if (op_active) begin
                i       = cyc - op_start;
                mcstall = (i < op_len - 1);
                mcdone  = (i == op_len - 1);
            end
            if (fr) begin
                e.flush   = 5'h1f;
                e.npv     = 1'b1;
                e.npc     = fpc;
                op_active = 0;
            end else begin
                reqs = int'(sreq);
                if (mcstall) reqs = reqs | (1 << (MC_STAGE - 1));
                if (reqs != 0) begin
                    k = 0;
                    for (int s = 0; s < STAGES; s++) if (reqs[s]) k = s + 1;
                    e.stall = 6'((1 << (k + 1)) - 1);
                end
                e.done = mcdone;
                if (mcdone) op_active = 0;
            end
            if (e.stall[0]) begin
                m_scyc = m_scyc + 1;
                m_wd++;
            end else begin
                m_wd = 0;
            end
            if (m_wd >= WDOG) m_dead = 1;
        end
        cyc++;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1, 5'b0, 0, 0, 0, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("stall",        32'(bus.stall),        32'(e.stall));
            check("flush",        32'(bus.flush),        32'(e.flush));
            check("new_pc_valid", 32'(bus.new_pc_valid), 32'(e.npv));
            check("new_pc",       bus.new_pc,            e.npc);
            check("mc_busy",      32'(bus.mc_busy),      32'(e.busy));
            check("mc_done",      32'(bus.mc_done),      32'(e.done));
            check("stall_cycles", bus.stall_cycles,      e.scyc);
            check("deadlock",     32'(bus.deadlock),     32'(e.dead));
        end
    end

    initial begin
        rst           = 1'b0;
        bus.stallreq  = '0;
        bus.mc_start  = 1'b0;
        bus.mc_len    = '0;
        bus.flush_req = 1'b0;
        bus.flush_pc  = '0;
        @(posedge clk);

        // Reset state, then ID load-use and release.
        drive(0, 5'b0, 0, 0, 0, 32'h0);
        idle(2);
        repeat (3) drive(1, 5'b00010, 0, 0, 0, 32'h0);
        idle(2);

        // Long multi-cycle op, then length 1 and 0.
        drive(1, 5'b0, 1, 33, 0, 32'h0);
        idle(34);
        drive(1, 5'b0, 1, 1, 0, 32'h0);
        idle(2);
        drive(1, 5'b0, 1, 0, 0, 32'h0);
        idle(2);

        // Flush on cycle 10 of a 33-cycle op.
        drive(1, 5'b0, 1, 33, 0, 32'h0);
        idle(8);
        drive(1, 5'b0, 0, 0, 1, 32'hBFC0_0380);
        idle(3);

        // MEM wait together with ID load-use.
        repeat (2) drive(1, 5'b01010, 0, 0, 0, 32'h0);
        idle(2);

        // Stall beyond the MC stage during RUN, plus an ignored restart.
        drive(1, 5'b0, 1, 10, 0, 32'h0);
        repeat (4) drive(1, 5'b10000, 0, 0, 0, 32'h0);
        drive(1, 5'b0, 1, 5, 0, 32'h0);
        idle(8);

        // Watchdog: stallreq[0] held for WDOG cycles from a clean reset.
        drive(0, 5'b0, 0, 0, 0, 32'h0);
        repeat (WDOG) drive(1, 5'b00001, 0, 0, 0, 32'h0);
        idle(3);
        drive(0, 5'b0, 0, 0, 0, 32'h0);
        idle(2);

        // Reset asserted mid-RUN.
        drive(1, 5'b0, 1, 20, 0, 32'h0);
        idle(5);
        drive(0, 5'b00100, 0, 0, 0, 32'h0);
        idle(3);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) != 0,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0,
                  $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                              : int'($urandom_range(0, 6)),
                  $urandom_range(0, 39) == 0,
                  $urandom);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
